// File: rtl/fft_cap_pkg.sv
// fft_cap_pkg: shared FSM state type, default widths and the bit-reverse helper
// for the FFT frame capture block.
package fft_cap_pkg;

    localparam int unsigned DEF_DATA_W = 14;
    localparam int unsigned DEF_LOG2_N = 10;
    localparam int unsigned REV_MAX_W  = 16;
    localparam int unsigned REV_IDX_W  = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        FLUSH   = 2'd2,
        DONE    = 2'd3
    } cap_state_t;

    // Reverses the low w bits of x; bits at and above w come back as 0.
    function automatic logic [REV_MAX_W-1:0] bitrev(input logic [REV_MAX_W-1:0] x,
                                                    input int unsigned         w);
        logic [REV_MAX_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < REV_MAX_W; i++) begin
            if (i < w) r[REV_IDX_W'(i)] = x[REV_IDX_W'(w - 1 - i)];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_frame_capture_if.sv
// fft_frame_capture_if: FFT sample stream, capture control, status and readout port.
// The buffer-release pulse is named buf_release because "release" is a reserved word.
interface fft_frame_capture_if
    import fft_cap_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned LOG2_N = DEF_LOG2_N,
    parameter int unsigned MAG_W  = 2 * DATA_W + 1
);
    logic                     arm;
    logic                     s_valid;
    logic                     s_ready;
    logic signed [DATA_W-1:0] s_re;
    logic signed [DATA_W-1:0] s_im;
    logic                     s_last;
    logic                     frame_done;
    logic                     frame_err;
    logic                     busy;
    logic [LOG2_N-1:0]        peak_bin;
    logic [MAG_W-1:0]         peak_mag;
    logic [LOG2_N-1:0]        rd_addr;
    logic [MAG_W-1:0]         rd_data;
    logic                     buf_release;

    modport master (
        output arm, s_valid, s_re, s_im, s_last, rd_addr, buf_release,
        input  s_ready, frame_done, frame_err, busy, peak_bin, peak_mag, rd_data
    );

    modport slave (
        input  arm, s_valid, s_re, s_im, s_last, rd_addr, buf_release,
        output s_ready, frame_done, frame_err, busy, peak_bin, peak_mag, rd_data
    );
endinterface

// File: rtl/fft_cap_ram.sv
// fft_cap_ram: N x MAG_W simple dual-port RAM, synchronous write, registered read.
module fft_cap_ram #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 29
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_data <= '0;
        else     rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/fft_frame_capture.sv
// fft_frame_capture: captures one FFT frame as |X|^2 per bin, tracks the peak bin and
// holds the frame for readout. Optional macro FFT_BITREV_EN: write address is the bit-reversed bin counter.
module fft_frame_capture
    import fft_cap_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned LOG2_N = DEF_LOG2_N,
    parameter int unsigned MAG_W  = 2 * DATA_W + 1
) (
    input  logic               sclk,
    input  logic               rst,
    fft_frame_capture_if.slave bus
);
    localparam int unsigned       PROD_W   = 2 * DATA_W;
    localparam logic [LOG2_N-1:0] LAST_BIN = '1;

    cap_state_t               state, state_n;
    logic [LOG2_N-1:0]        cnt, cnt_n;
    logic                     flush_2nd, flush_2nd_n;
    logic                     s_ready_q, busy_q, frame_done_q, frame_err_q;
    logic                     s_ready_n, busy_n, frame_done_n, frame_err_n;
    logic [LOG2_N-1:0]        peak_bin_q;
    logic [MAG_W-1:0]         peak_mag_q;
    logic                     accept_c, arm_c;
    logic [LOG2_N-1:0]        wr_addr_c;
    logic signed [DATA_W-1:0] re_in, im_in;
    logic                     v1, v2;
    logic signed [PROD_W-1:0] re_sq, im_sq;
    logic [LOG2_N-1:0]        idx1, idx2;
    logic [MAG_W-1:0]         mag2;
    logic [MAG_W-1:0]         rd_q;

    assign re_in    = bus.s_re;
    assign im_in    = bus.s_im;
    assign accept_c = (state == CAPTURE) && s_ready_q && bus.s_valid;
    assign arm_c    = (state == IDLE) && bus.arm;

`ifdef FFT_BITREV_EN
    assign wr_addr_c = LOG2_N'(bitrev(REV_MAX_W'(cnt), LOG2_N));
`else
    assign wr_addr_c = cnt;
`endif

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            flush_2nd    <= 1'b0;
            s_ready_q    <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            flush_2nd    <= flush_2nd_n;
            s_ready_q    <= s_ready_n;
            busy_q       <= busy_n;
            frame_done_q <= frame_done_n;
            frame_err_q  <= frame_err_n;
        end
    end

    // Next state; status outputs are registered from the next state so they line up with it.
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        flush_2nd_n  = flush_2nd;
        frame_done_n = 1'b0;
        frame_err_n  = frame_err_q;
        case (state)
            IDLE: begin
                if (bus.arm) begin
                    state_n     = CAPTURE;
                    cnt_n       = '0;
                    frame_err_n = 1'b0;
                end
            end
            CAPTURE: begin
                if (accept_c) begin
                    cnt_n = cnt + 1'b1;
                    if (bus.s_last || (cnt == LAST_BIN)) begin
                        state_n     = FLUSH;
                        flush_2nd_n = 1'b0;
                        if (bus.s_last != (cnt == LAST_BIN)) frame_err_n = 1'b1;
                    end
                end
            end
            FLUSH: begin
                flush_2nd_n = 1'b1;
                if (flush_2nd) begin
                    state_n      = DONE;
                    frame_done_n = 1'b1;
                end
            end
            DONE: begin
                if (bus.buf_release) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        s_ready_n = (state_n == CAPTURE);
        busy_n    = (state_n == CAPTURE) || (state_n == FLUSH);
    end

    // Power pipeline: squares, then the zero-extended sum; the bin address rides along.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            v1    <= 1'b0;
            v2    <= 1'b0;
            re_sq <= '0;
            im_sq <= '0;
            idx1  <= '0;
            idx2  <= '0;
            mag2  <= '0;
        end else begin
            v1    <= accept_c;
            v2    <= v1;
            re_sq <= PROD_W'(re_in) * PROD_W'(re_in);
            im_sq <= PROD_W'(im_in) * PROD_W'(im_in);
            idx1  <= wr_addr_c;
            idx2  <= idx1;
            mag2  <= MAG_W'($unsigned(re_sq)) + MAG_W'($unsigned(im_sq));
        end
    end

    // Strict compare keeps the earliest bin on ties.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            peak_bin_q <= '0;
            peak_mag_q <= '0;
        end else if (arm_c) begin
            peak_bin_q <= '0;
            peak_mag_q <= '0;
        end else if (v2 && (mag2 > peak_mag_q)) begin
            peak_bin_q <= idx2;
            peak_mag_q <= mag2;
        end
    end

    fft_cap_ram #(
        .ADDR_W (LOG2_N),
        .DATA_W (MAG_W)
    ) u_ram (
        .clk     (sclk),
        .rst     (rst),
        .wr_en   (v2),
        .wr_addr (idx2),
        .wr_data (mag2),
        .rd_addr (bus.rd_addr),
        .rd_data (rd_q)
    );

    assign bus.s_ready    = s_ready_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.peak_bin   = peak_bin_q;
    assign bus.peak_mag   = peak_mag_q;
    assign bus.rd_data    = rd_q;
endmodule

// File: tb/tb_fft_frame_capture.sv
// tb_fft_frame_capture: directed frames with a scoreboard of expected bin powers,
// read back through the RAM port after each frame completes.
module tb_fft_frame_capture;
    localparam int unsigned DW = 14;
    localparam int unsigned LN = 10;
    localparam int unsigned MW = 2 * DW + 1;
    localparam int          N  = 1 << LN;

    typedef struct {
        int unsigned     addr;
        longint unsigned mag;
    } exp_t;

    logic sclk = 1'b0;
    logic rst  = 1'b1;
    always #5 sclk = ~sclk;

    fft_frame_capture_if #(.DATA_W(DW), .LOG2_N(LN), .MAG_W(MW)) bus ();

    fft_frame_capture #(.DATA_W(DW), .LOG2_N(LN), .MAG_W(MW)) dut (
        .sclk (sclk),
        .rst  (rst),
        .bus  (bus.slave)
    );

    int              checks = 0;
    int              errors = 0;
    exp_t            sb[$];
    int              re_arr[N];
    int              im_arr[N];
    longint unsigned pk_mag;
    int unsigned     pk_bin;
    longint unsigned mag_at0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge sclk);
        #1;
    endtask

    function automatic int unsigned waddr(input int unsigned i);
`ifdef FFT_BITREV_EN
        int unsigned r = 0;
        for (int b = 0; b < int'(LN); b++) if (i[b]) r |= (1 << (int'(LN) - 1 - b));
        return r;
`else
        return i;
`endif
    endfunction

    function automatic longint unsigned pwr(input int re, input int im);
        return longint'(re) * longint'(re) + longint'(im) * longint'(im);
    endfunction

    task automatic fill(input int re, input int im);
        for (int i = 0; i < N; i++) begin
            re_arr[i] = re;
            im_arr[i] = im;
        end
    endtask

    // Arm with a beat already presented: IDLE must not accept it.
    task automatic arm_cycle();
        check("idle_ready", 64'(bus.s_ready), 64'd0);
        bus.arm = 1'b1; bus.s_valid = 1'b1; bus.s_last = 1'b0;
        bus.s_re = DW'(re_arr[0]); bus.s_im = DW'(im_arr[0]);
        step();
        bus.arm = 1'b0; bus.s_valid = 1'b0;
        pk_mag = 0; pk_bin = 0;
        check("arm_clears_err", 64'(bus.frame_err), 64'd0);
    endtask

    task automatic capture(input int last_idx, input int abort_at);
        int bad = 0;
        for (int i = 0; i < N; i++) begin
            if (i == abort_at) begin
                check("ready_pattern", 64'(bad), 64'd0);
                return;
            end
            bus.s_valid = 1'b1;
            bus.s_re    = DW'(re_arr[i]);
            bus.s_im    = DW'(im_arr[i]);
            bus.s_last  = (i == last_idx);
            if (bus.s_ready !== 1'b1) bad++;
            sb.push_back('{addr: waddr(i), mag: pwr(re_arr[i], im_arr[i])});
            if (pwr(re_arr[i], im_arr[i]) > pk_mag) begin
                pk_mag = pwr(re_arr[i], im_arr[i]);
                pk_bin = waddr(i);
            end
            step();
            if (i == last_idx || i == N - 1) break;
        end
        bus.s_valid = 1'b0; bus.s_last = 1'b0;
        check("ready_pattern", 64'(bad), 64'd0);
        check("ready_drop", 64'(bus.s_ready), 64'd0);
        check("flush_busy", 64'(bus.busy), 64'd1);
    endtask

    task automatic finish_frame(input logic exp_err);
        int   lat = 0;
        exp_t e;
        while (bus.frame_done !== 1'b1 && lat < 10) begin
            step();
            lat++;
        end
        check("done_latency", 64'(lat), 64'd2);
        check("done_busy", 64'(bus.busy), 64'd0);
        check("frame_err", 64'(bus.frame_err), 64'(exp_err));
        check("peak_bin", 64'(bus.peak_bin), 64'(pk_bin));
        check("peak_mag", 64'(bus.peak_mag), 64'(pk_mag));
        step();
        check("done_pulse", 64'(bus.frame_done), 64'd0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            bus.rd_addr = LN'(e.addr);
            step();
            check("rd_data", 64'(bus.rd_data), 64'(e.mag));
        end
    endtask

    task automatic release_buf(input logic with_arm);
        bus.buf_release = 1'b1; bus.arm = with_arm;
        step();
        bus.buf_release = 1'b0; bus.arm = 1'b0;
        check("release_idle_ready", 64'(bus.s_ready), 64'd0);
        check("release_idle_busy", 64'(bus.busy), 64'd0);
    endtask

    initial begin
        int bad;
        bus.arm = 1'b0; bus.s_valid = 1'b0; bus.s_re = '0; bus.s_im = '0;
        bus.s_last = 1'b0; bus.rd_addr = '0; bus.buf_release = 1'b0;
        #2;
        check("rst_ready", 64'(bus.s_ready), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.frame_done), 64'd0);
        check("rst_err", 64'(bus.frame_err), 64'd0);
        check("rst_peak_bin", 64'(bus.peak_bin), 64'd0);
        check("rst_peak_mag", 64'(bus.peak_mag), 64'd0);
        check("rst_rd_data", 64'(bus.rd_data), 64'd0);
        step();
        rst = 1'b0;
        step(); step();

        // Full frame of a constant 3-4j sample; release and arm together
        fill(3, -4);
        arm_cycle();
        capture(N - 1, -1);
        finish_frame(1'b0);
        release_buf(1'b1);

        // Single tone at bin 37
        fill(0, 0); re_arr[37] = 1000;
        arm_cycle();
        capture(N - 1, -1);
        finish_frame(1'b0);
        check("tone_peak_bin", 64'(bus.peak_bin), 64'(waddr(37)));
        check("tone_peak_mag", 64'(bus.peak_mag), 64'd1000000);
        release_buf(1'b0);

        // Two equal full-scale bins: no overflow, lower bin wins
        fill(0, 0);
        re_arr[5] = -8192; im_arr[5] = -8192; re_arr[9] = -8192; im_arr[9] = -8192;
        arm_cycle();
        capture(N - 1, -1);
        finish_frame(1'b0);
        check("tie_peak_bin", 64'(bus.peak_bin), 64'(waddr(5)));
        check("tie_peak_mag", 64'(bus.peak_mag), 64'd134217728);
        release_buf(1'b0);

        // Short frame: s_last on beat 511; arm in DONE is ignored
        for (int i = 0; i < N; i++) begin
            re_arr[i] = (i % 50) - 25;
            im_arr[i] = ((i * 7) % 40) - 20;
        end
        mag_at0 = pwr(re_arr[0], im_arr[0]);
        arm_cycle();
        capture(511, -1);
        finish_frame(1'b1);
        bus.arm = 1'b1;
        step();
        bus.arm = 1'b0;
        check("done_arm_err", 64'(bus.frame_err), 64'd1);
        check("done_arm_busy", 64'(bus.busy), 64'd0);
        release_buf(1'b0);

        // s_valid without arm: nothing accepted, RAM untouched
        bad = 0;
        bus.s_valid = 1'b1; bus.s_re = DW'(100); bus.s_im = DW'(100);
        for (int i = 0; i < 16; i++) begin
            if (bus.s_ready !== 1'b0) bad++;
            step();
        end
        bus.s_valid = 1'b0;
        check("noarm_ready", 64'(bad), 64'd0);
        bus.rd_addr = '0;
        step();
        check("noarm_ram", 64'(bus.rd_data), 64'(mag_at0));

        // release during CAPTURE has no effect
        fill(3, -4);
        arm_cycle();
        bus.buf_release = 1'b1;
        step();
        bus.buf_release = 1'b0;
        check("cap_release_busy", 64'(bus.busy), 64'd1);
        check("cap_release_ready", 64'(bus.s_ready), 64'd1);
        capture(N - 1, -1);
        finish_frame(1'b0);
        release_buf(1'b0);

        // Reset mid-frame at beat 300, then a clean full frame
        arm_cycle();
        capture(N - 1, 300);
        check("pre_rst_peak", 64'(bus.peak_mag), 64'd25);
        rst = 1'b1;
        #1;
        check("midrst_ready", 64'(bus.s_ready), 64'd0);
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_peak_mag", 64'(bus.peak_mag), 64'd0);
        check("midrst_peak_bin", 64'(bus.peak_bin), 64'd0);
        check("midrst_rd_data", 64'(bus.rd_data), 64'd0);
        sb.delete();
        bus.s_valid = 1'b0; bus.s_last = 1'b0;
        step();
        rst = 1'b0;
        step();
        arm_cycle();
        capture(N - 1, -1);
        finish_frame(1'b0);
        release_buf(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
